// File: rtl/mem_write_buffer_pkg.sv
// Shared memory-system definitions: default address/data widths, cache block
// geometry, write-buffer FSM encoding and a block-tag extraction helper.
// No logic; imported by the write buffer and its storage sub-module.
package mem_write_buffer_pkg;

    localparam int MWB_AW      = 16;
    localparam int MWB_DW      = 16;
    localparam int MWB_BLK_LSB = 4;
    localparam int MWB_TAG_W   = MWB_AW - MWB_BLK_LSB;

    // Memory-port ownership FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    // Block tag of an address at the default geometry (shared with cache tag logic)
    function automatic logic [MWB_TAG_W-1:0] blk_tag(input logic [MWB_AW-1:0] addr);
        return addr[MWB_AW-1:MWB_BLK_LSB];
    endfunction

endpackage

// File: rtl/mem_write_buffer_wb_fifo.sv
// Purpose: circular store buffer (addr/data per entry) with valid bits and a
//          per-entry block-tag compare against an external address.
// Latency: entry written at edge N is visible at head from cycle N+1.
// Backpressure: push ignored when full (full evaluated before same-cycle pop).
// Ports: clk_i/rst_i; push_*_i enqueue; pop_i dequeue head; cmp_addr_i tag probe;
//        head_*_o oldest entry; full_o/empty_o/count_o status; conflict_o tag hit.
module mem_write_buffer_wb_fifo
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = MWB_AW,
    parameter int DW      = MWB_DW,
    parameter int BLK_LSB = MWB_BLK_LSB
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_addr_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    input  logic [AW-1:0]            cmp_addr_i,
    output logic [AW-1:0]            head_addr_o,
    output logic [DW-1:0]            head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     conflict_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;
    logic [DEPTH-1:0] hit_vec;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // full is taken from the registered count, so a pop in the same cycle
    // never frees a slot for the concurrent push.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage needs no reset; validity lives in vld_q.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // push and pop never target the same slot: that would need count==0
            if (push_ok) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop_ok) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = vld_q[i] && (addr_q[i][AW-1:BLK_LSB] == cmp_addr_i[AW-1:BLK_LSB]);
        end
    end

    assign conflict_o = |hit_vec;

endmodule

// File: rtl/mem_write_buffer.sv
// Purpose: posted-store buffer in front of single-ported memory; owns the port
//          mux and hands it to the miss-fill FSM after flushing same-block stores.
// Latency: store enqueued at edge N issues at earliest in cycle N+1, 1 store/cycle.
// Backpressure: full must stall the pipeline; a store while full is dropped.
// Ports: wr_* store in; full/empty/count status; fill_* miss FSM side;
//        fill_grant/conflict handshake; mem_* to memory4c.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = MWB_AW,
    parameter int DW      = MWB_DW,
    parameter int BLK_LSB = MWB_BLK_LSB
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   fill_req,
    input  logic [AW-1:0]          fill_addr,
    input  logic                   fill_en,
    output logic                   fill_grant,
    output logic                   conflict,
    output logic                   mem_en,
    output logic                   mem_wr,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_data
);

    logic [1:0]    state_q, state_d;
    logic          drain;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    mem_write_buffer_wb_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DW     (DW),
        .BLK_LSB(BLK_LSB)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (wr_req),
        .push_addr_i(wr_addr),
        .push_data_i(wr_data),
        .pop_i      (drain),
        .cmp_addr_i (fill_addr),
        .head_addr_o(head_addr),
        .head_data_o(head_data),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .conflict_o (conflict)
    );

    // A non-conflicting fill request freezes draining so the port is quiet for
    // the cycle before the grant; a conflicting one keeps draining (flush).
    assign drain = !empty && (state_q != ST_FILL) && !(fill_req && !conflict);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fill_req) state_d = conflict ? ST_FLUSH : ST_FILL;
            end
            ST_FLUSH: begin
                if (!fill_req)     state_d = ST_IDLE;
                else if (!conflict) state_d = ST_FILL;
            end
            ST_FILL: begin
                // later conflicts do not revoke an active grant
                if (!fill_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign fill_grant = (state_q == ST_FILL);

    always_comb begin
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = fill_addr;
        mem_data = '0;
        if (state_q == ST_FILL) begin
            mem_en = fill_en;
        end else if (drain) begin
            mem_en   = 1'b1;
            mem_wr   = 1'b1;
            mem_addr = head_addr;
            mem_data = head_data;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        fill_req;
    logic [15:0] fill_addr;
    logic        fill_en;
    logic        fill_grant;
    logic        conflict;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;

    int errors = 0;
    int checks = 0;
    int grant_wr_viol = 0;

    logic [15:0] log_addr [$];
    logic [15:0] log_data [$];
    logic [15:0] mem_model [logic [15:0]];

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH(4), .AW(16), .DW(16), .BLK_LSB(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .fill_req  (fill_req),
        .fill_addr (fill_addr),
        .fill_en   (fill_en),
        .fill_grant(fill_grant),
        .conflict  (conflict),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    // Memory model: one-cycle write on the rising edge
    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
            mem_model[mem_addr] = mem_data;
        end
        if (fill_grant && mem_wr) grant_wr_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        fill_req = 1'b0; fill_addr = '0; fill_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (fill_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", fill_grant); end
        checks++; if ({mem_en, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_en_wr: got %b want 00", {mem_en, mem_wr}); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", mem_data); end
    endtask

    task automatic test_basic_drain();
        logic [15:0] ea [3] = '{16'h0010, 16'h0012, 16'h0020};
        logic [15:0] ed [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        int base;
        do_reset();
        base = log_addr.size();
        wr_req = 1'b1; wr_addr = 16'h0010; wr_data = 16'hAAAA;
        tick();
        wr_addr = 16'h0012; wr_data = 16'hBBBB; settle();
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0010 || mem_data !== 16'hAAAA) begin errors++; $display("FAIL drain_c1: got wr=%b %h/%h want 1 0010/AAAA", mem_wr, mem_addr, mem_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL drain_cnt1: got %0d want 1", count); end
        tick();
        wr_addr = 16'h0020; wr_data = 16'hCCCC; settle();
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0012 || mem_data !== 16'hBBBB) begin errors++; $display("FAIL drain_c2: got wr=%b %h/%h want 1 0012/BBBB", mem_wr, mem_addr, mem_data); end
        tick();
        wr_req = 1'b0; settle();
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0020 || mem_data !== 16'hCCCC) begin errors++; $display("FAIL drain_c3: got wr=%b %h/%h want 1 0020/CCCC", mem_wr, mem_addr, mem_data); end
        tick();
        checks++; if (count !== 3'd0 || empty !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL drain_end: got cnt=%0d empty=%b wr=%b want 0 1 0", count, empty, mem_wr); end
        checks++; if (log_addr.size() !== base + 3) begin errors++; $display("FAIL drain_nwr: got %0d want %0d", log_addr.size(), base + 3); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (log_addr[base+k] !== ea[k] || log_data[base+k] !== ed[k]) begin errors++; $display("FAIL drain_order%0d: got %h/%h want %h/%h", k, log_addr[base+k], log_data[base+k], ea[k], ed[k]); end
        end
    endtask

    task automatic test_fill_holdoff();
        logic [2:0] exp_cnt;
        do_reset();
        fill_req = 1'b1; fill_addr = 16'h0100; settle();
        checks++; if (fill_grant !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL hold_idle: got grant=%b en=%b want 0 0", fill_grant, mem_en); end
        tick();
        checks++; if (fill_grant !== 1'b1) begin errors++; $display("FAIL hold_grant: got %b want 1", fill_grant); end
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_addr = 16'h0200 + 16'(2*i); wr_data = 16'h1000 + 16'(i);
            fill_en = (i % 2 == 0); settle();
            checks++; if (mem_en !== fill_en || mem_wr !== 1'b0 || mem_addr !== 16'h0100) begin errors++; $display("FAIL hold_port%0d: got en=%b wr=%b addr=%h want %b 0 0100", i, mem_en, mem_wr, mem_addr, fill_en); end
            tick();
            exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
            checks++; if (count !== exp_cnt) begin errors++; $display("FAIL hold_cnt%0d: got %0d want %0d", i, count, exp_cnt); end
            checks++; if (full !== (i >= 3)) begin errors++; $display("FAIL hold_full%0d: got %b want %b", i, full, (i >= 3)); end
        end
        wr_req = 1'b0; fill_en = 1'b0;
    endtask

    // Continues from the full, granted state left by test_fill_holdoff
    task automatic test_full_simultaneous();
        logic [15:0] ea [5] = '{16'h0200, 16'h0202, 16'h0204, 16'h0206, 16'h0300};
        logic [15:0] ed [5] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h3333};
        int base;
        base = log_addr.size();
        fill_req = 1'b0;
        tick();
        wr_req = 1'b1; wr_addr = 16'h0300; wr_data = 16'h3333; settle();
        checks++; if (full !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL fsim_c1: got full=%b wr=%b addr=%h want 1 1 0200", full, mem_wr, mem_addr); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fsim_cnt3: got %0d want 3", count); end
        fill_req = 1'b1; fill_addr = 16'h0100; settle();
        checks++; if (mem_wr !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL fsim_quiet: got wr=%b conflict=%b want 0 0", mem_wr, conflict); end
        tick();
        checks++; if (count !== 3'd4 || fill_grant !== 1'b1) begin errors++; $display("FAIL fsim_cnt4: got cnt=%0d grant=%b want 4 1", count, fill_grant); end
        wr_req = 1'b0; fill_req = 1'b0;
        repeat (7) tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fsim_empty: got %0d want 0", count); end
        checks++; if (log_addr.size() !== base + 5) begin errors++; $display("FAIL fsim_nwr: got %0d want %0d", log_addr.size(), base + 5); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (log_addr[base+k] !== ea[k] || log_data[base+k] !== ed[k]) begin errors++; $display("FAIL fsim_order%0d: got %h/%h want %h/%h", k, log_addr[base+k], log_data[base+k], ea[k], ed[k]); end
        end
        checks++; if (grant_wr_viol !== 0) begin errors++; $display("FAIL grant_no_wr: got %0d writes while granted want 0", grant_wr_viol); end
    endtask

    task automatic test_flush();
        int base;
        do_reset();
        base = log_addr.size();
        fill_req = 1'b1; fill_addr = 16'h0500;
        tick();
        wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 16'h1111;
        tick();
        wr_addr = 16'h0034; wr_data = 16'h3434;
        tick();
        wr_req = 1'b0; fill_req = 1'b0;
        tick();
        fill_req = 1'b1; fill_addr = 16'h0030; settle();
        checks++; if (conflict !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0100 || fill_grant !== 1'b0) begin errors++; $display("FAIL flush_c1: got conf=%b wr=%b addr=%h grant=%b want 1 1 0100 0", conflict, mem_wr, mem_addr, fill_grant); end
        tick();
        checks++; if (conflict !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0034 || mem_data !== 16'h3434) begin errors++; $display("FAIL flush_c2: got conf=%b wr=%b %h/%h want 1 1 0034/3434", conflict, mem_wr, mem_addr, mem_data); end
        tick();
        checks++; if (empty !== 1'b1 || conflict !== 1'b0 || mem_en !== 1'b0 || fill_grant !== 1'b0) begin errors++; $display("FAIL flush_c3: got empty=%b conf=%b en=%b grant=%b want 1 0 0 0", empty, conflict, mem_en, fill_grant); end
        tick();
        checks++; if (fill_grant !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0030) begin errors++; $display("FAIL flush_grant: got grant=%b wr=%b addr=%h want 1 0 0030", fill_grant, mem_wr, mem_addr); end
        fill_addr = 16'h0040; fill_en = 1'b1; settle();
        checks++; if (mem_addr !== 16'h0040 || mem_en !== 1'b1) begin errors++; $display("FAIL flush_follow: got addr=%h en=%b want 0040 1", mem_addr, mem_en); end
        checks++; if (log_addr.size() !== base + 2 || log_addr[base] !== 16'h0100 || log_addr[base+1] !== 16'h0034) begin errors++; $display("FAIL flush_order: got n=%0d first=%h want n=%0d 0100 then 0034", log_addr.size() - base, log_addr[base], 2); end
        fill_req = 1'b0; fill_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int base;
        logic [15:0] a;
        logic [15:0] d;
        do_reset();
        base = log_addr.size();
        for (int i = 0; i < 10; i++) begin
            wr_req = 1'b1; wr_addr = 16'h0800 + 16'(i * 18); wr_data = 16'hD000 + 16'(i * 257);
            tick();
            wr_req = 1'b0;
            tick();
        end
        repeat (3) tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_cnt: got %0d want 0", count); end
        checks++; if (log_addr.size() !== base + 10) begin errors++; $display("FAIL wrap_nwr: got %0d want %0d", log_addr.size() - base, 10); end
        for (int i = 0; i < 10; i++) begin
            a = 16'h0800 + 16'(i * 18);
            d = 16'hD000 + 16'(i * 257);
            checks++; if (!mem_model.exists(a) || mem_model[a] !== d) begin errors++; $display("FAIL wrap_mem%0d: addr %h got %h want %h", i, a, mem_model.exists(a) ? mem_model[a] : 16'h0000, d); end
        end
    endtask

    task automatic test_reset_in_fill();
        int base;
        do_reset();
        fill_req = 1'b1; fill_addr = 16'h0100;
        tick();
        wr_req = 1'b1; wr_addr = 16'h0700; wr_data = 16'h7777;
        tick();
        wr_addr = 16'h0710; wr_data = 16'h7171;
        tick();
        wr_req = 1'b0; fill_en = 1'b1; settle();
        checks++; if (count !== 3'd2 || fill_grant !== 1'b1) begin errors++; $display("FAIL rstf_pre: got cnt=%0d grant=%b want 2 1", count, fill_grant); end
        base = log_addr.size();
        rst = 1'b1;
        tick();
        checks++; if (count !== 3'd0 || fill_grant !== 1'b0 || mem_en !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstf_post: got cnt=%0d grant=%b en=%b empty=%b want 0 0 0 1", count, fill_grant, mem_en, empty); end
        rst = 1'b0; fill_req = 1'b0; fill_en = 1'b0;
        wr_req = 1'b1; wr_addr = 16'h0600; wr_data = 16'h6666;
        tick();
        wr_req = 1'b0; settle();
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 16'h0600 || mem_data !== 16'h6666) begin errors++; $display("FAIL rstf_new: got wr=%b %h/%h want 1 0600/6666", mem_wr, mem_addr, mem_data); end
        tick();
        checks++; if (count !== 3'd0 || log_addr.size() !== base + 1) begin errors++; $display("FAIL rstf_end: got cnt=%0d nwr=%0d want 0 1", count, log_addr.size() - base); end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_fill_holdoff();
        test_full_simultaneous();
        test_flush();
        test_wrap();
        test_reset_in_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-store FIFO between the data-side store path and the single-ported multi-cycle main memory (memory4c).
- Accepts store address/data from the MEM stage in one cycle and drains one store per cycle to memory when the port is free.
- Owns the memory port mux: it grants the port to the cache-miss fill FSM, first flushing any pending store to the same block so the fill reads current data.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
AW, 16, address width
DW, 16, data width
BLK_LSB, 4, low address bits inside one cache block; block tag = addr[AW-1:BLK_LSB]

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
wr_req  in  1  store request from MEM stage (opcode SW)
wr_addr  in  AW  store address
wr_data  in  DW  store data
full  out  1  buffer full; pipeline must stall a store
empty  out  1  no valid entries
count  out  $clog2(DEPTH)+1  valid entry count
fill_req  in  1  miss FSM requests the memory port; held until fill done
fill_addr  in  AW  address driven by miss FSM
fill_en  in  1  memory enable from miss FSM
fill_grant  out  1  port owned by miss FSM
conflict  out  1  a valid entry's block tag equals fill_addr's block tag
mem_en  out  1  to memory4c enable
mem_wr  out  1  to memory4c wr
mem_addr  out  AW  to memory4c addr
mem_data  out  DW  to memory4c data_in

Behaviour:
- Reset (sync, rst=1 at edge): all entries invalid, head=tail=0, count=0, state IDLE. After reset: empty=1, full=0, fill_grant=0, mem_en=mem_wr=0, mem_addr=0, mem_data=0. Reset mid-drain or mid-fill discards all entries and revokes the grant in the same edge.
- Storage: circular FIFO, head/tail pointers wrap modulo DEPTH, count in 0..DEPTH. full=(count==DEPTH), empty=(count==0).
- Enqueue: wr_req && !full at an edge writes entry[tail], tail+1. wr_req while full is ignored, with no state change (the pipeline is required to stall on full).
- Issue/dequeue: drain is asserted when !empty && state!=FILL && !(fill_req && !conflict). While drain is asserted: mem_en=1, mem_wr=1, mem_addr/mem_data=entry[head] (combinational), and head+1 at the edge. Memory writes complete in one cycle.
- Latency: a store enqueued at edge N can issue at earliest in cycle N+1. With no fill activity, throughput is 1 store/cycle.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. When full, a same-cycle dequeue does not admit the store (full is evaluated before dequeue).
- conflict is combinational: OR over valid entries of (entry.addr[AW-1:BLK_LSB] == fill_addr[AW-1:BLK_LSB]).
- FSM states:
  - IDLE: fill_req && conflict -> FLUSH; fill_req && !conflict -> FILL; otherwise stay.
  - FLUSH: drain continues; when !conflict -> FILL; if fill_req drops -> IDLE.
  - FILL: fill_grant=1; when !fill_req -> IDLE.
- In IDLE with fill_req && !conflict, nothing issues that cycle (port is quiet for 1 cycle before FILL).
- In FILL: mem_en=fill_en, mem_wr=0, mem_addr=fill_addr, mem_data=0. Stores may still enqueue; conflicts arising during FILL do not revoke the grant.
- Outside FILL and when not draining: mem_en=mem_wr=0, mem_addr=fill_addr, mem_data=0.

Decomposition:
- Shared memory-system package: AW/DW defaults, BLK_LSB, FSM state encoding (IDLE=2'd0, FLUSH=2'd1, FILL=2'd2), and a block-tag extraction function.
- One natural sub-module: wb_fifo (storage, pointers, count, full/empty, per-entry tag compare vector). The top level holds the FSM and the port mux.

Test Plan:
- Reset, then 3 stores (0x0010/0xAAAA, 0x0012/0xBBBB, 0x0020/0xCCCC) on consecutive cycles, no fill -> mem_wr pulses in cycles 1-3 after each enqueue, in order; count returns to 0.
- Fill FSM held off (fill_req=1, fill_addr=0x0100, no conflict), 5 stores -> 4 accepted, full=1 on the 5th (ignored); fill_grant=1 one cycle after fill_req; no mem_wr while fill_grant=1.
- Buffer holds 0x0034 and 0x0100; fill_req with fill_addr=0x0030 -> conflict=1, state FLUSH, both stores drain in order, then fill_grant=1 exactly one cycle after the 0x0034 entry leaves; mem_addr then follows fill_addr.
- Full buffer with simultaneous wr_req and drain -> store not admitted, count=3; next cycle the store is admitted and count=4.
- Wrap-around: 10 stores streamed with a 1-cycle gap -> pointers wrap twice, memory contents match all 10 writes.
- Assert rst during FILL with 2 entries pending -> next cycle count=0, fill_grant=0, mem_en=0; after release, a new store drains normally.
